// File: rtl/updown_mod_counter_pkg.sv
// Shared definitions for the up/down modulo-N counter: direction, mode and
// saturation FSM state encodings.
package updown_mod_counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

   typedef enum logic {
      COUNTING      = 1'b0,
      HELD_AT_LIMIT = 1'b1
   } state_e;

endpackage

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo-N counter with clear, checked parallel load, wrap or
// saturate mode, registered boundary/load-error pulses and a cascade terminal count.
module updown_mod_counter
   import updown_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned MODULUS  = 16,
   parameter int unsigned SATURATE = 0
) (
   input  logic             input_CLK,
   input  logic             input_RSTN,
   input  logic             input_ENA,
   input  logic             input_DIR,
   input  logic             input_CLR,
   input  logic             input_LOAD,
   input  logic [WIDTH-1:0] input_D,
   output logic [WIDTH-1:0] output_Y,
   output logic             overflow,
   output logic             underflow,
   output logic             output_TC,
   output logic             output_LDERR
);

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be in 1..16");
   end
   if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
   localparam logic             SatEn  = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] y_q, y_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             lderr_q, lderr_d;
   state_e           state_q, state_d;
   logic             held_dir_q, held_dir_d;

   logic [WIDTH:0]   y_inc, y_dec;
   logic             at_max, at_zero;
   logic             up_lim, down_lim;
   logic             toward_lim;
   logic             d_legal;

   always_comb begin
      y_inc   = {1'b0, y_q} + (WIDTH+1)'(1);
      y_dec   = {1'b0, y_q} - (WIDTH+1)'(1);
      at_max  = (y_q == MaxVal);
      at_zero = (y_q == '0);
      // Carry/borrow only fire on the all-ones/zero boundary, so they agree with
      // the explicit comparators (carry matters only when MODULUS == 2**WIDTH).
      up_lim     = at_max | y_inc[WIDTH];
      down_lim   = at_zero | y_dec[WIDTH];
      toward_lim = (input_DIR == DIR_UP) ? up_lim : down_lim;
      d_legal    = (32'(input_D) < MODULUS);
   end

   always_comb begin
      y_d        = y_q;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      lderr_d    = 1'b0;
      state_d    = state_q;
      held_dir_d = held_dir_q;

      if (input_CLR) begin
         y_d     = '0;
         state_d = COUNTING;
      end else if (input_LOAD) begin
         if (d_legal) begin
            y_d     = input_D;
            state_d = COUNTING;
         end else begin
            lderr_d = 1'b1;
         end
      end else if (input_ENA) begin
         if (SatEn && state_q == HELD_AT_LIMIT && input_DIR == held_dir_q) begin
            // Pinned at the limit: keep re-pulsing the flag for every push.
            ovf_d = (input_DIR == DIR_UP);
            unf_d = (input_DIR == DIR_DOWN);
         end else if (toward_lim) begin
            ovf_d = (input_DIR == DIR_UP);
            unf_d = (input_DIR == DIR_DOWN);
            if (SatEn) begin
               state_d    = HELD_AT_LIMIT;
               held_dir_d = input_DIR;
            end else begin
               y_d = (input_DIR == DIR_UP) ? '0 : MaxVal;
            end
         end else begin
            y_d     = (input_DIR == DIR_UP) ? y_inc[WIDTH-1:0] : y_dec[WIDTH-1:0];
            state_d = COUNTING;
         end
      end
   end

   always_ff @(posedge input_CLK or negedge input_RSTN) begin
      if (!input_RSTN) begin
         y_q        <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         lderr_q    <= 1'b0;
         state_q    <= COUNTING;
         held_dir_q <= DIR_UP;
      end else begin
         y_q        <= y_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         lderr_q    <= lderr_d;
         state_q    <= state_d;
         held_dir_q <= held_dir_d;
      end
   end

   always_comb begin
      output_Y     = y_q;
      overflow     = ovf_q;
      underflow    = unf_q;
      output_LDERR = lderr_q;
      output_TC    = input_ENA & ~input_CLR & ~input_LOAD &
                     (((input_DIR == DIR_UP) & at_max) | ((input_DIR == DIR_DOWN) & at_zero));
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (mod-10 wrap, mod-10 saturate,
// mod-16 wrap) share one stimulus stream; each step is checked against one of them.
module tb_updown_mod_counter;

   typedef struct {
      logic       clr;
      logic       load;
      logic       ena;
      logic       dir;
      logic [3:0] d;
      logic       tc;
      logic [3:0] y;
      logic       ovf;
      logic       unf;
      logic       lderr;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ena = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
   logic [3:0] d = '0;

   logic [3:0] y0, y1, y2;
   logic       ovf0, ovf1, ovf2, unf0, unf1, unf2;
   logic       tc0, tc1, tc2, lde0, lde1, lde2;

   int checks = 0;
   int failures = 0;
   vec_t exp_q[$];
   vec_t tab[$];

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap10 (
      .input_CLK(clk), .input_RSTN(rstn), .input_ENA(ena), .input_DIR(dir),
      .input_CLR(clr), .input_LOAD(load), .input_D(d), .output_Y(y0),
      .overflow(ovf0), .underflow(unf0), .output_TC(tc0), .output_LDERR(lde0)
   );
   updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat10 (
      .input_CLK(clk), .input_RSTN(rstn), .input_ENA(ena), .input_DIR(dir),
      .input_CLR(clr), .input_LOAD(load), .input_D(d), .output_Y(y1),
      .overflow(ovf1), .underflow(unf1), .output_TC(tc1), .output_LDERR(lde1)
   );
   updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_wrap16 (
      .input_CLK(clk), .input_RSTN(rstn), .input_ENA(ena), .input_DIR(dir),
      .input_CLR(clr), .input_LOAD(load), .input_D(d), .output_Y(y2),
      .overflow(ovf2), .underflow(unf2), .output_TC(tc2), .output_LDERR(lde2)
   );

   function automatic vec_t mk(input logic c, input logic l, input logic e, input logic dr,
                               input int dv, input logic t, input int yv, input logic o,
                               input logic u, input logic le);
      vec_t v;
      v.clr = c; v.load = l; v.ena = e; v.dir = dr; v.d = 4'(dv);
      v.tc = t; v.y = 4'(yv); v.ovf = o; v.unf = u; v.lderr = le;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic get_outs(input int inst, output logic [3:0] y, output logic o,
                           output logic u, output logic le, output logic t);
      case (inst)
         0:       begin y = y0; o = ovf0; u = unf0; le = lde0; t = tc0; end
         1:       begin y = y1; o = ovf1; u = unf1; le = lde1; t = tc1; end
         default: begin y = y2; o = ovf2; u = unf2; le = lde2; t = tc2; end
      endcase
   endtask

   task automatic step(input int inst, input string tag, input int idx, input vec_t v);
      vec_t e;
      logic [3:0] y;
      logic o, u, le, t;
      @(negedge clk);
      clr = v.clr; load = v.load; ena = v.ena; dir = v.dir; d = v.d;
      #1;
      get_outs(inst, y, o, u, le, t);
      chk($sformatf("%s[%0d].tc", tag, idx), int'(t), int'(v.tc));
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      get_outs(inst, y, o, u, le, t);
      chk($sformatf("%s[%0d].y", tag, idx), int'(y), int'(e.y));
      chk($sformatf("%s[%0d].ovf", tag, idx), int'(o), int'(e.ovf));
      chk($sformatf("%s[%0d].unf", tag, idx), int'(u), int'(e.unf));
      chk($sformatf("%s[%0d].lderr", tag, idx), int'(le), int'(e.lderr));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".y0"}, int'(y0), 0);
      chk({tag, ".y1"}, int'(y1), 0);
      chk({tag, ".y2"}, int'(y2), 0);
      chk({tag, ".flags0"}, int'({ovf0, unf0, lde0}), 0);
      chk({tag, ".flags1"}, int'({ovf1, unf1, lde1}), 0);
      chk({tag, ".flags2"}, int'({ovf2, unf2, lde2}), 0);
   endtask

   initial begin
      // Mod-10 wrap: 12 up counts from 0, overflow when 9 -> 0.
      for (int k = 0; k < 12; k++)
         tab.push_back(mk(0, 0, 1, 1, 0, k == 9, (k + 1) % 10, k == 9, 0, 0));
      tab.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 0));
      tab.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
      tab.push_back(mk(0, 0, 1, 0, 0,  1, 9, 0, 1, 0));
      tab.push_back(mk(0, 1, 0, 0, 12, 0, 9, 0, 0, 1));
      tab.push_back(mk(0, 1, 1, 1, 12, 0, 9, 0, 0, 1));
      tab.push_back(mk(0, 0, 0, 1, 0,  0, 9, 0, 0, 0));
      tab.push_back(mk(0, 1, 0, 0, 7,  0, 7, 0, 0, 0));
      tab.push_back(mk(1, 1, 1, 1, 5,  0, 0, 0, 0, 0));
      tab.push_back(mk(1, 1, 0, 0, 12, 0, 0, 0, 0, 0));
      tab.push_back(mk(0, 1, 1, 1, 9,  0, 9, 0, 0, 0));
      tab.push_back(mk(0, 0, 1, 1, 0,  1, 0, 1, 0, 0));
      tab.push_back(mk(0, 0, 1, 0, 0,  1, 9, 0, 1, 0));
      tab.push_back(mk(0, 0, 1, 0, 0,  0, 8, 0, 0, 0));
      tab.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0));
      tab.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < tab.size(); i++) step(0, "wrap10", i, tab[i]);

      // Saturating mod-10: pin at 9, re-pulse overflow, release downward.
      step(1, "sat10", 0, mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      step(1, "sat10", 1, mk(0, 1, 0, 0, 8,  0, 8, 0, 0, 0));
      step(1, "sat10", 2, mk(0, 0, 1, 1, 0,  0, 9, 0, 0, 0));
      step(1, "sat10", 3, mk(0, 0, 1, 1, 0,  1, 9, 1, 0, 0));
      step(1, "sat10", 4, mk(0, 0, 1, 1, 0,  1, 9, 1, 0, 0));
      step(1, "sat10", 5, mk(0, 0, 1, 1, 0,  1, 9, 1, 0, 0));
      step(1, "sat10", 6, mk(0, 0, 1, 0, 0,  0, 8, 0, 0, 0));
      step(1, "sat10", 7, mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
      step(1, "sat10", 8, mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 0));
      step(1, "sat10", 9, mk(0, 0, 1, 0, 0,  1, 0, 0, 1, 0));
      step(1, "sat10", 10, mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
      step(1, "sat10", 11, mk(0, 1, 0, 0, 10, 0, 1, 0, 0, 1));

      // Full-range mod-16: load beats enable, then natural wrap both ways.
      step(2, "wrap16", 0, mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      step(2, "wrap16", 1, mk(0, 1, 1, 1, 15, 0, 15, 0, 0, 0));
      step(2, "wrap16", 2, mk(0, 0, 1, 1, 0,  1, 0, 1, 0, 0));
      step(2, "wrap16", 3, mk(0, 0, 1, 0, 0,  1, 15, 0, 1, 0));
      step(2, "wrap16", 4, mk(0, 0, 1, 1, 0,  1, 0, 1, 0, 0));

      // Asynchronous reset mid-cycle, then counting on the first edge after release.
      step(0, "async", 0, mk(0, 1, 0, 0, 7, 0, 7, 0, 0, 0));
      @(negedge clk);
      clr = 0; load = 0; ena = 0; dir = 1; d = '0;
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk_reset_state("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      step(0, "async", 1, mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo-N counter with synchronous clear, parallel load, wrap or saturate mode, and registered overflow/underflow flags. It generalises the lab's 4-bit enable counter to arbitrary width and modulus. It adds direction control and a combinational terminal-count output, so instances cascade into multi-digit counters such as BCD clocks and timers in the lab designs.

## Interface
- WIDTH, 4, counter width in bits; legal range 1..16
- MODULUS, 16, count range is 0..MODULUS-1; legal range 2..2**WIDTH
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries
- input_CLK  in  1  clock; all state changes on the rising edge
- input_RSTN  in  1  asynchronous, active-low reset
- input_ENA  in  1  count enable
- input_DIR  in  1  1 = count up, 0 = count down
- input_CLR  in  1  synchronous clear to 0
- input_LOAD  in  1  synchronous parallel load
- input_D  in  WIDTH  load value
- output_Y  out  WIDTH  current count, registered
- overflow  out  1  one-cycle pulse: up-count hit the upper boundary
- underflow  out  1  one-cycle pulse: down-count hit the lower boundary
- output_TC  out  1  combinational terminal count, for cascading
- output_LDERR  out  1  one-cycle pulse: load value rejected

## Operation
- Reset (input_RSTN = 0, asynchronous): output_Y = 0, overflow = 0, underflow = 0, output_LDERR = 0. Takes effect immediately, including mid-count or mid-load.
- Per-edge priority: CLR > LOAD > ENA > hold.
- CLR: output_Y = 0. Flags are 0 on the next cycle.
- LOAD with input_D < MODULUS: output_Y = input_D, no flags.
- LOAD with input_D >= MODULUS: output_Y holds and output_LDERR pulses for one cycle.
- ENA with DIR = 1:
  - Y < MODULUS-1: Y+1.
  - Y = MODULUS-1: Y becomes 0 (SATURATE = 0) or holds (SATURATE = 1); overflow pulses in both modes.
- ENA with DIR = 0:
  - Y > 0: Y-1.
  - Y = 0: Y becomes MODULUS-1 (SATURATE = 0) or holds (SATURATE = 1); underflow pulses in both modes.
- ENA = 0 and no CLR/LOAD: output_Y holds, flags 0.
- output_TC = ENA & ~CLR & ~LOAD & ((DIR & Y == MODULUS-1) | (~DIR & Y == 0)). Feeds the next stage's input_ENA.
- Arithmetic: compute in WIDTH+1 bits; compare against MODULUS-1 cast to WIDTH bits. When MODULUS = 2**WIDTH, the natural wrap must match the explicit rule.
- Mode state: a 2-state FSM, COUNTING and HELD_AT_LIMIT, used only when SATURATE = 1. HELD_AT_LIMIT is entered on a saturating event. It is left on CLR, a legal LOAD, or ENA in the opposite direction. While HELD_AT_LIMIT, continued ENA toward the limit re-pulses the flag every cycle.
- Illegal parameters stop elaboration with an error: MODULUS < 2 or MODULUS > 2**WIDTH.

## Timing
- Latency: output_Y, overflow, underflow and output_LDERR update one cycle after the qualifying input edge.
- Each flag asserts for exactly one cycle per event; back-to-back events give back-to-back pulses.
- output_TC has zero latency (combinational from inputs and Y) and must not depend on the flag registers.
- Simultaneous CLR and LOAD: CLR wins, no LDERR.
- Simultaneous LOAD and ENA: LOAD wins, no overflow or underflow.
- Reset deassertion: counting may begin on the first rising edge after input_RSTN rises.

## Structure
- Shared counter definitions file (package-equivalent include) holds:
  - direction constants DIR_UP = 1, DIR_DOWN = 0
  - mode constants MODE_WRAP = 0, MODE_SAT = 1
  - FSM state encodings COUNTING = 0, HELD_AT_LIMIT = 1
- Single module, no sub-module. Boundary comparators and next-state logic stay inline.
- Cascade example, two instances forming BCD 00..99, lives in the lab top level and not in this block.

## Test plan
- WIDTH = 4, MODULUS = 10, SATURATE = 0; reset, then DIR = 1, ENA = 1 for 12 cycles -> Y runs 0..9, 0, 1; overflow high only in the cycle Y = 0 after 9; output_TC high while Y = 9.
- Same config; DIR = 0 from Y = 0 -> Y = 9, underflow pulses once; then LOAD with D = 12 -> Y holds at 9, output_LDERR pulses once.
- SATURATE = 1, MODULUS = 10; count up from 8 with ENA held -> Y = 9 and stays 9; overflow pulses every cycle at the limit; DIR = 0 -> Y = 8, flags 0.
- WIDTH = 4, MODULUS = 16; LOAD D = 15 with ENA = 1 in the same cycle -> Y = 15, no overflow; next ENA up -> Y = 0 with an overflow pulse.
- Reset and priority: CLR, LOAD (D = 5) and ENA all asserted at Y = 7 -> Y = 0, all flags 0; drive input_RSTN low mid-cycle -> Y = 0 immediately, before the next edge.
